// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file arbiter: FSM state encoding,
// op-vector bit positions and default data/address widths.
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  // Bit positions inside a 3-bit op / rf_valid vector.
  localparam int OP_WR  = 2;
  localparam int OP_RD1 = 1;
  localparam int OP_RD2 = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    CAPT  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requesting index
// at or after ptr, searching upward with wrap, plus an any-request flag.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  // Scan from the farthest candidate down to ptr so the nearest one wins last.
  always_comb begin : scan
    int idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        winner  = IDX_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates NUM_REQ requesters onto the single register file and runs its
// three-phase access (issue valid+addresses, drop valid, capture read data).
// Requester 0 is the core, requester 1 the result-readout port.
// Optional build macro REGFILE_ARB_R0_GUARD_EN: suppresses writes to r0 and
// raises a sticky err flag; without it r0 writes pass and err is 0.
//
// Handshake: a requester raises req with op/addresses/wdata stable and keeps
// it high until it sees the one-cycle ack; operands are sampled only at the
// grant edge; req must be low by the edge ending the IDLE cycle after ack.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [3*NUM_REQ-1:0]      op,
  input  logic [ADDR_W*NUM_REQ-1:0] raddr1,
  input  logic [ADDR_W*NUM_REQ-1:0] raddr2,
  input  logic [ADDR_W*NUM_REQ-1:0] waddr,
  input  logic [DATA_W*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata1,
  output logic [DATA_W-1:0]         rdata2,
  output logic                      busy,
  output logic [2:0]                rf_valid,
  output logic [ADDR_W-1:0]         rf_raddr1,
  output logic [ADDR_W-1:0]         rf_raddr2,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  output logic                      err,
  output state_t                    dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [1:0]         rd_q;

  logic [2:0]         op_sel;
  logic [2:0]         valid_sel;
  logic [ADDR_W-1:0]  ra1_sel;
  logic [ADDR_W-1:0]  ra2_sel;
  logic [ADDR_W-1:0]  wa_sel;
  logic [DATA_W-1:0]  wd_sel;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (pick),
    .any_req (any_req)
  );

  // Operands of the requester that would win this cycle.
  assign op_sel  = op[3*int'(pick) +: 3];
  assign ra1_sel = raddr1[ADDR_W*int'(pick) +: ADDR_W];
  assign ra2_sel = raddr2[ADDR_W*int'(pick) +: ADDR_W];
  assign wa_sel  = waddr[ADDR_W*int'(pick) +: ADDR_W];
  assign wd_sel  = wdata[DATA_W*int'(pick) +: DATA_W];

  assign dbg_state = state;

`ifdef REGFILE_ARB_R0_GUARD_EN
  logic guard_hit;
  assign guard_hit = op_sel[OP_WR] && (wa_sel == '0);
  assign valid_sel = {op_sel[OP_WR] & ~guard_hit, op_sel[OP_RD1], op_sel[OP_RD2]};

  // Sticky flag: set when a write to r0 is granted, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == IDLE && any_req && guard_hit) begin
      err <= 1'b1;
    end
  end
`else
  assign valid_sel = op_sel;
  assign err       = 1'b0;
`endif

  // Access sequencer: IDLE -> ISSUE -> HOLD -> CAPT -> IDLE, outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ack       <= '0;
      rdata1    <= '0;
      rdata2    <= '0;
      rf_valid  <= '0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      winner    <= '0;
      ptr       <= '0;
      rd_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            winner    <= pick;
            rd_q      <= {op_sel[OP_RD1], op_sel[OP_RD2]};
            rf_valid  <= valid_sel;
            rf_raddr1 <= ra1_sel;
            rf_raddr2 <= ra2_sel;
            rf_waddr  <= wa_sel;
            rf_wdata  <= wd_sel;
          end
        end
        ISSUE: begin
          rf_valid <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          if (rd_q[1]) rdata1 <= rf_rdata1;
          if (rd_q[0]) rdata2 <= rf_rdata2;
          ack   <= NUM_REQ'(1) << winner;
          ptr   <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state <= CAPT;
        end
        CAPT: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: behavioural register file, directed and
// randomized operations checked against a spec-level reference model.
module tb_regfile_arbiter;
  import regfile_pkg::*;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req;
  logic [3*N-1:0]  op;
  logic [AW*N-1:0] raddr1, raddr2, waddr;
  logic [DW*N-1:0] wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata1, rdata2;
  logic            busy, err;
  logic [2:0]      rf_valid;
  logic [AW-1:0]   rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [DW-1:0]   rf_rdata1 = '0;
  logic [DW-1:0]   rf_rdata2 = '0;
  state_t          dbg_state;

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op),
    .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr), .wdata(wdata),
    .ack(ack), .rdata1(rdata1), .rdata2(rdata2), .busy(busy),
    .rf_valid(rf_valid), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .err(err), .dbg_state(dbg_state)
  );

  function automatic logic [DW-1:0] seed(input int i);
    return DW'(i * 2 + 3);
  endfunction

  // ---------------- register file model ----------------
  logic [DW-1:0] rf_mem [32];
  logic          mem_seeded = 1'b0;

  always @(posedge clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= seed(i);
      mem_seeded <= 1'b1;
    end else begin
      if (rf_valid[2]) rf_mem[rf_waddr] <= rf_wdata;
      if (rf_valid[1]) rf_rdata1 <= rf_mem[rf_raddr1];
      if (rf_valid[0]) rf_rdata2 <= rf_mem[rf_raddr2];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] ref_mem [32];
  int            ref_ptr;
  logic [DW-1:0] exp_rd1, exp_rd2;
  logic          exp_err;
  logic [2*DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // First requesting index at or after p, searching upward with wrap.
  function automatic int model_pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++)
      if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic bit guard_on();
`ifdef REGFILE_ARB_R0_GUARD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic drive_req(input int r, input logic [2:0] o, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    op[r*3 +: 3]      = o;
    raddr1[r*AW +: AW] = a1;
    raddr2[r*AW +: AW] = a2;
    waddr[r*AW +: AW]  = wa;
    wdata[r*DW +: DW]  = wd;
    req[r]             = 1'b1;
  endtask

  // One full operation from an idle arbiter, checked cycle by cycle.
  task automatic run_op(input int r, input logic [2:0] o, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic [2:0]      ev;
    logic [2*DW-1:0] pair;
    int              w;
    drive_req(r, o, a1, a2, wa, wd);
    w  = model_pick(req, ref_ptr);
    ev = o;
    if (guard_on() && o[2] && wa == '0) begin
      ev[2]   = 1'b0;
      exp_err = 1'b1;
    end
    if (o[1]) exp_rd1 = ref_mem[a1];
    if (o[0]) exp_rd2 = ref_mem[a2];
    if (ev[2]) ref_mem[wa] = wd;
    exp_q.push_back({exp_rd1, exp_rd2});

    @(negedge clk);
    check("issue_state", dbg_state, ISSUE);
    check("issue_busy", busy, 1);
    check("issue_valid", rf_valid, ev);
    check("issue_raddr1", rf_raddr1, a1);
    check("issue_raddr2", rf_raddr2, a2);
    check("issue_waddr", rf_waddr, wa);
    check("issue_wdata", rf_wdata, wd);
    // Operands changing after grant must be ignored.
    drive_req(r, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 8'($urandom));

    @(negedge clk);
    check("hold_valid", rf_valid, 0);
    check("hold_raddr1", rf_raddr1, a1);
    check("hold_waddr", rf_waddr, wa);
    check("hold_ack", ack, 0);

    @(negedge clk);
    pair = exp_q.pop_front();
    check("capt_ack", ack, N'(1) << w);
    check("capt_rdata1", rdata1, pair[2*DW-1:DW]);
    check("capt_rdata2", rdata2, pair[DW-1:0]);
    check("capt_err", err, exp_err);
    req[r]  = 1'b0;
    ref_ptr = (w + 1) % N;

    @(negedge clk);
    check("idle_ack", ack, 0);
    check("idle_busy", busy, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [AW-1:0] ca1 [N];
    logic [AW-1:0] ca2 [N];
    int            w, cnt;
    req = '0; op = '0; raddr1 = '0; raddr2 = '0; waddr = '0; wdata = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = seed(i);
    ref_ptr = 0; exp_rd1 = '0; exp_rd2 = '0; exp_err = 1'b0;

    // Reset for two cycles
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_rdata2", rdata2, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", rf_valid, 0);
    check("rst_raddr1", rf_raddr1, 0);
    check("rst_raddr2", rf_raddr2, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_noreq_valid", rf_valid, 0);
    check("idle_noreq_busy", busy, 0);

    // Single read r2/r3
    run_op(0, 3'b011, 5'd2, 5'd3, 5'd0, 8'h00);
    check("tp_single_rd1", rdata1, 8'd7);
    check("tp_single_rd2", rdata2, 8'd9);

    // Write 0x5A to r4 from requester 1, then read it back
    run_op(1, 3'b100, 5'd0, 5'd0, 5'd4, 8'h5A);
    run_op(1, 3'b010, 5'd4, 5'd0, 5'd0, 8'h00);
    check("tp_readback", rdata1, 8'h5A);

    // Contention: both requesters held high for four grants
    ca1[0] = 5'd7;  ca2[0] = 5'd8;
    ca1[1] = 5'd10; ca2[1] = 5'd11;
    for (int r = 0; r < N; r++) drive_req(r, 3'b011, ca1[r], ca2[r], 5'd0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      w = model_pick(req, ref_ptr);
      exp_rd1 = ref_mem[ca1[w]];
      exp_rd2 = ref_mem[ca2[w]];
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (ack == '0 && cnt < 8);
      check("cont_gap", cnt, (k == 0) ? 3 : 4);
      check("cont_ack", ack, N'(1) << w);
      check("cont_rdata1", rdata1, exp_rd1);
      check("cont_rdata2", rdata2, exp_rd2);
      if (k == 3) req = '0;
      ref_ptr = (w + 1) % N;
    end
    @(negedge clk);
    check("cont_end_busy", busy, 0);

    // Reset during HOLD abandons the operation
    drive_req(0, 3'b011, 5'd5, 5'd6, 5'd0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("midrst_in_hold", dbg_state, HOLD);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ack", ack, 0);
    check("midrst_valid", rf_valid, 0);
    check("midrst_raddr1", rf_raddr1, 0);
    check("midrst_raddr2", rf_raddr2, 0);
    check("midrst_rdata1", rdata1, 0);
    check("midrst_state", dbg_state, IDLE);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_ptr = 0; exp_rd1 = '0; exp_rd2 = '0; exp_err = 1'b0;
    run_op(0, 3'b011, 5'd5, 5'd6, 5'd0, 8'h00);

    // Randomized operations
    for (int k = 0; k < 24; k++) begin
      logic [AW-1:0] wa;
      wa = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, 31));
      run_op($urandom_range(0, N - 1), 3'($urandom_range(0, 7)),
             AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), wa,
             DW'($urandom_range(0, 255)));
    end

    // Write 0x33 to r0, then read r0 back
    run_op(0, 3'b100, 5'd0, 5'd0, 5'd0, 8'h33);
    check("r0_err", err, guard_on() ? 1 : 0);
    run_op(1, 3'b010, 5'd0, 5'd0, 5'd0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
